// File: rtl/shape_ctrl_initiator_pkg.sv
// Shared modeling package for the shape processor CTRL SFR: field encodings,
// register image, response status codes and the field legality rules.
package shape_processor_modeling;

   // SHAPE field: 4..6 are reserved, 7 means "leave SHAPE as it is"
   typedef enum logic [2:0] {
      CIRCLE      = 3'd0,
      RECTANGLE   = 3'd1,
      SQUARE      = 3'd2,
      TRIANGLE    = 3'd3,
      SHAPE_RSVD4 = 3'd4,
      SHAPE_RSVD5 = 3'd5,
      SHAPE_RSVD6 = 3'd6,
      KEEP_SHAPE  = 3'd7
   } shape_e;

   // OPERATION field: 3..6 are reserved, 7 means "leave OPERATION as it is"
   typedef enum logic [2:0] {
      AREA           = 3'd0,
      PERIMETER      = 3'd1,
      IS_SQUARE      = 3'd2,
      OP_RSVD3       = 3'd3,
      OP_RSVD4       = 3'd4,
      OP_RSVD5       = 3'd5,
      OP_RSVD6       = 3'd6,
      KEEP_OPERATION = 3'd7
   } operation_e;

   // Per-request outcome reported on the response port
   typedef enum logic [1:0] {
      OK        = 2'd0,
      REJECTED  = 2'd1,
      BUS_ERROR = 2'd2,
      MISMATCH  = 2'd3
   } status_e;

   // CTRL register image: SHAPE in [2:0], OPERATION in [5:3], rest reads as zero
   typedef struct packed {
      logic [25:0] rsvd;
      operation_e  operation;
      shape_e      shape;
   } ctrl_sfr_reg;

   // Architecturally meaningful part of CTRL, as tracked by the initiator
   typedef struct packed {
      shape_e     shape;
      operation_e op;
   } shadow_t;

   function automatic logic is_reserved_shape(shape_e s);
      return (s == SHAPE_RSVD4) || (s == SHAPE_RSVD5) || (s == SHAPE_RSVD6);
   endfunction

   function automatic logic is_reserved_operation(operation_e o);
      return (o == OP_RSVD3) || (o == OP_RSVD4) || (o == OP_RSVD5) || (o == OP_RSVD6);
   endfunction

   // Only defined codes combine; IS_SQUARE makes sense for rectangles and squares only
   function automatic logic is_legal_combination(shape_e s, operation_e o);
      logic defined;
      defined = (s == CIRCLE || s == RECTANGLE || s == SQUARE || s == TRIANGLE) &&
                (o == AREA || o == PERIMETER || o == IS_SQUARE);
      if (o == IS_SQUARE) begin
         return defined && (s == RECTANGLE || s == SQUARE);
      end
      return defined;
   endfunction

   function automatic ctrl_sfr_reg make_ctrl(shape_e s, operation_e o);
      ctrl_sfr_reg c;
      c           = '0;
      c.shape     = s;
      c.operation = o;
      return c;
   endfunction

   function automatic shape_e ctrl_shape(logic [31:0] d);
      ctrl_sfr_reg c;
      c = ctrl_sfr_reg'(d);
      return c.shape;
   endfunction

   function automatic operation_e ctrl_operation(logic [31:0] d);
      ctrl_sfr_reg c;
      c = ctrl_sfr_reg'(d);
      return c.operation;
   endfunction

endpackage

// File: rtl/shape_ctrl_initiator_if.sv
// Request, bus and response signals of the CTRL initiator. The master modport
// is the initiator's view; the slave modport is the command source / bus side.
interface shape_ctrl_if;
   import shape_processor_modeling::*;

   logic        req_valid;
   logic        req_ready;
   shape_e      req_shape;
   operation_e  req_op;
   logic        write;
   logic [31:0] write_data;
   logic        read;
   logic [31:0] read_data;
   logic        error;
   logic        rsp_valid;
   logic        rsp_ready;
   status_e     rsp_status;
   logic [31:0] rsp_ctrl;

   modport master (
      input  req_valid, req_shape, req_op, read_data, error, rsp_ready,
      output req_ready, write, write_data, read, rsp_valid, rsp_status, rsp_ctrl
   );

   modport slave (
      output req_valid, req_shape, req_op, read_data, error, rsp_ready,
      input  req_ready, write, write_data, read, rsp_valid, rsp_status, rsp_ctrl
   );

endinterface

// File: rtl/shape_ctrl_initiator_predictor.sv
// Predicts what CTRL should read back after writing a request, given the
// current shadow of the SFR. Purely combinational.
module shape_ctrl_predictor
   import shape_processor_modeling::*;
(
   input  shape_e     req_shape_i,
   input  operation_e req_op_i,
   input  shadow_t    shadow_i,
   output shadow_t    expected_o,
   output logic       legal_o
);

   shape_e     eff_shape;
   operation_e eff_op;

   // Resolve KEEP_* against the shadow, then decide whether the hardware takes the write
   always_comb begin
      eff_shape = (req_shape_i == KEEP_SHAPE)     ? shadow_i.shape : req_shape_i;
      eff_op    = (req_op_i    == KEEP_OPERATION) ? shadow_i.op    : req_op_i;
      legal_o   = !is_reserved_shape(req_shape_i) &&
                  !is_reserved_operation(req_op_i) &&
                  is_legal_combination(eff_shape, eff_op);
      expected_o = shadow_i;
      if (legal_o) begin
         expected_o.shape = eff_shape;
         expected_o.op    = eff_op;
      end
   end

endmodule

// File: rtl/shape_ctrl_initiator.sv
// CTRL SFR initiator: accepts {shape, operation} requests, writes CTRL, reads
// it back, checks the readback against a shadow-based prediction (retrying on
// disagreement) and reports one status per request.
module shape_ctrl_initiator
   import shape_processor_modeling::*;
#(
   parameter int         MAX_RETRIES   = 2,
   parameter shape_e     RST_SHAPE     = CIRCLE,
   parameter operation_e RST_OPERATION = AREA
) (
   input  logic          clk,
   input  logic          rst,
   shape_ctrl_if.master  bus
);

   // A zero-retry build still needs a one-bit counter to stay well formed
   localparam int RETRY_W = (MAX_RETRIES > 0) ? $clog2(MAX_RETRIES + 1) : 1;

   typedef enum logic [2:0] {
      S_IDLE,
      S_WR,
      S_WR_RESP,
      S_RD,
      S_RD_RESP,
      S_RSP
   } state_e;

   state_e               state_q;
   shadow_t              shadow_q;
   shadow_t              expected_q;
   logic                 legal_q;
   logic [RETRY_W-1:0]   retry_q;

   logic                 req_ready_q;
   logic                 write_q;
   ctrl_sfr_reg          write_data_q;
   logic                 read_q;
   logic                 rsp_valid_q;
   status_e              rsp_status_q;
   logic [31:0]          rsp_ctrl_q;

   shadow_t              pred_expected;
   logic                 pred_legal;
   logic                 rd_match;

   // Prediction is taken from the live request so it can be latched on accept
   shape_ctrl_predictor u_predictor (
      .req_shape_i (bus.req_shape),
      .req_op_i    (bus.req_op),
      .shadow_i    (shadow_q),
      .expected_o  (pred_expected),
      .legal_o     (pred_legal)
   );

   // Only SHAPE and OPERATION take part in the readback comparison
   assign rd_match = (ctrl_shape(bus.read_data)     == expected_q.shape) &&
                     (ctrl_operation(bus.read_data) == expected_q.op);

   // Request/response FSM with registered bus strobes, shadow and retry count
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q          <= S_IDLE;
         shadow_q.shape   <= RST_SHAPE;
         shadow_q.op      <= RST_OPERATION;
         expected_q.shape <= RST_SHAPE;
         expected_q.op    <= RST_OPERATION;
         legal_q          <= 1'b0;
         retry_q          <= '0;
         req_ready_q      <= 1'b1;
         write_q          <= 1'b0;
         write_data_q     <= '0;
         read_q           <= 1'b0;
         rsp_valid_q      <= 1'b0;
         rsp_status_q     <= OK;
         rsp_ctrl_q       <= '0;
      end else begin
         // Strobes are single-cycle unless a state explicitly raises them
         write_q <= 1'b0;
         read_q  <= 1'b0;
         case (state_q)
            S_IDLE: begin
               if (bus.req_valid && req_ready_q) begin
                  write_data_q <= make_ctrl(bus.req_shape, bus.req_op);
                  expected_q   <= pred_expected;
                  legal_q      <= pred_legal;
                  req_ready_q  <= 1'b0;
                  write_q      <= 1'b1;
                  state_q      <= S_WR;
               end
            end
            S_WR: begin
               state_q <= S_WR_RESP;
            end
            S_WR_RESP: begin
               if (bus.error) begin
                  // Write never landed: nothing was read, so report an empty image
                  rsp_status_q <= BUS_ERROR;
                  rsp_ctrl_q   <= '0;
                  rsp_valid_q  <= 1'b1;
                  state_q      <= S_RSP;
               end else begin
                  read_q  <= 1'b1;
                  state_q <= S_RD;
               end
            end
            S_RD: begin
               state_q <= S_RD_RESP;
            end
            S_RD_RESP: begin
               if (bus.error) begin
                  rsp_status_q <= BUS_ERROR;
                  rsp_ctrl_q   <= bus.read_data;
                  rsp_valid_q  <= 1'b1;
                  state_q      <= S_RSP;
               end else if (rd_match) begin
                  rsp_status_q <= legal_q ? OK : REJECTED;
                  if (legal_q) begin
                     shadow_q <= expected_q;
                  end
                  rsp_ctrl_q  <= bus.read_data;
                  rsp_valid_q <= 1'b1;
                  state_q     <= S_RSP;
               end else if (retry_q < RETRY_W'(MAX_RETRIES)) begin
                  // Same write_data is re-issued; the prediction stays valid
                  retry_q <= retry_q + 1'b1;
                  write_q <= 1'b1;
                  state_q <= S_WR;
               end else begin
                  // Give up and trust the hardware so later KEEP_* resolve correctly
                  rsp_status_q   <= MISMATCH;
                  shadow_q.shape <= ctrl_shape(bus.read_data);
                  shadow_q.op    <= ctrl_operation(bus.read_data);
                  rsp_ctrl_q     <= bus.read_data;
                  rsp_valid_q    <= 1'b1;
                  state_q        <= S_RSP;
               end
            end
            S_RSP: begin
               if (bus.rsp_ready) begin
                  rsp_valid_q <= 1'b0;
                  req_ready_q <= 1'b1;
                  retry_q     <= '0;
                  state_q     <= S_IDLE;
               end
            end
            default: begin
               rsp_valid_q <= 1'b0;
               req_ready_q <= 1'b1;
               retry_q     <= '0;
               state_q     <= S_IDLE;
            end
         endcase
      end
   end

   assign bus.req_ready  = req_ready_q;
   assign bus.write      = write_q;
   assign bus.write_data = write_data_q;
   assign bus.read       = read_q;
   assign bus.rsp_valid  = rsp_valid_q;
   assign bus.rsp_status = rsp_status_q;
   assign bus.rsp_ctrl   = rsp_ctrl_q;

endmodule

// File: tb/tb_shape_ctrl_initiator.sv
// Directed bench for shape_ctrl_initiator: a small CTRL SFR bus model answers
// writes/reads; a vector table drives requests and checks each response.
module tb_shape_ctrl_initiator;
   import shape_processor_modeling::*;

   logic clk;
   logic rst;

   shape_ctrl_if bus ();

   shape_ctrl_initiator #(
      .MAX_RETRIES   (2),
      .RST_SHAPE     (CIRCLE),
      .RST_OPERATION (AREA)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.master)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [2:0]  shape;
      logic [2:0]  op;
      bit          err_wr;
      bit          err_rd;
      int          corrupt;
      int          hold;
      logic [1:0]  status;
      logic [31:0] ctrl;
      int          writes;
      int          reads;
      int          lat;
   } vec_t;

   int total = 0;
   int bad   = 0;

   // bus model state / configuration
   logic [2:0]  sfr_s, sfr_o;
   logic [2:0]  ws, wo, es, eo;
   logic        resp_wr, resp_rd;
   logic [31:0] resp_wd;
   logic [31:0] last_wdata = '0;
   int          nwr = 0, nrd = 0, overlap_cnt = 0;
   int          rd_base = 0;
   bit          cfg_err_wr = 0, cfg_err_rd = 0;
   int          cfg_corrupt = 0;

   function automatic logic [31:0] img(input logic [2:0] s, input logic [2:0] o);
      return {26'd0, o, s};
   endfunction

   function automatic vec_t mk(input logic [2:0] s, input logic [2:0] o, input bit ew, input bit er,
                               input int cor, input int hold, input logic [1:0] st,
                               input logic [31:0] ctl, input int w, input int r, input int lat);
      vec_t v;
      v.shape = s; v.op = o; v.err_wr = ew; v.err_rd = er; v.corrupt = cor; v.hold = hold;
      v.status = st; v.ctrl = ctl; v.writes = w; v.reads = r; v.lat = lat;
      return v;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // CTRL SFR model: a write updates it under the hardware's own rules; a
   // response (error / read data) appears in the cycle after each strobe
   always @(posedge clk) begin
      resp_wr = bus.write;
      resp_rd = bus.read;
      resp_wd = bus.write_data;
      if (rst) begin
         sfr_s = 3'd0;
         sfr_o = 3'd0;
      end else begin
         if (resp_wr && resp_rd) overlap_cnt++;
         if (resp_wr) begin
            nwr++;
            last_wdata = resp_wd;
            if (!cfg_err_wr) begin
               ws = resp_wd[2:0];
               wo = resp_wd[5:3];
               es = (ws == 3'd7) ? sfr_s : ws;
               eo = (wo == 3'd7) ? sfr_o : wo;
               if (!(ws inside {3'd4, 3'd5, 3'd6}) && !(wo inside {3'd3, 3'd4, 3'd5, 3'd6}) &&
                   es <= 3'd3 && eo <= 3'd2 && !(eo == 3'd2 && !(es == 3'd1 || es == 3'd2))) begin
                  sfr_s = es;
                  sfr_o = eo;
               end
            end
         end
         if (resp_rd) nrd++;
      end
      #1;
      bus.error     = 1'b0;
      bus.read_data = '0;
      if (!rst) begin
         if (resp_wr) bus.error = cfg_err_wr;
         if (resp_rd) begin
            bus.error = cfg_err_rd;
            if (nrd - rd_base <= cfg_corrupt) bus.read_data = img(3'd3, 3'd1);
            else                              bus.read_data = img(sfr_s, sfr_o);
         end
      end
   end

   task automatic wait_idle(output bit ok);
      ok = 0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (bus.req_ready) begin
            ok = 1;
            break;
         end
      end
   endtask

   task automatic run_req(input vec_t v, input int idx);
      int lat, w0, r0, ov0;
      bit ok;
      cfg_err_wr  = v.err_wr;
      cfg_err_rd  = v.err_rd;
      cfg_corrupt = v.corrupt;
      w0 = nwr; r0 = nrd; ov0 = overlap_cnt; rd_base = nrd;
      wait_idle(ok);
      chk($sformatf("v%0d_idle", idx), 32'(ok), 32'd1);
      if (!ok) return;
      bus.req_valid = 1'b1;
      bus.req_shape = shape_e'(v.shape);
      bus.req_op    = operation_e'(v.op);
      lat = 0;
      do begin
         @(negedge clk);
         bus.req_valid = 1'b0;
         lat++;
      end while (!bus.rsp_valid && lat < 80);
      chk($sformatf("v%0d_rsp_valid", idx), 32'(bus.rsp_valid), 32'd1);
      chk($sformatf("v%0d_latency", idx), 32'(lat), 32'(v.lat));
      chk($sformatf("v%0d_status", idx), 32'(bus.rsp_status), 32'(v.status));
      chk($sformatf("v%0d_rsp_ctrl", idx), bus.rsp_ctrl, v.ctrl);
      for (int h = 0; h < v.hold; h++) begin
         @(negedge clk);
         chk($sformatf("v%0d_hold_valid", idx), 32'(bus.rsp_valid), 32'd1);
         chk($sformatf("v%0d_hold_status", idx), 32'(bus.rsp_status), 32'(v.status));
         chk($sformatf("v%0d_hold_ctrl", idx), bus.rsp_ctrl, v.ctrl);
         chk($sformatf("v%0d_hold_req_ready", idx), 32'(bus.req_ready), 32'd0);
      end
      bus.rsp_ready = 1'b1;
      @(negedge clk);
      bus.rsp_ready = 1'b0;
      chk($sformatf("v%0d_rsp_cleared", idx), 32'(bus.rsp_valid), 32'd0);
      chk($sformatf("v%0d_req_ready_back", idx), 32'(bus.req_ready), 32'd1);
      chk($sformatf("v%0d_writes", idx), 32'(nwr - w0), 32'(v.writes));
      chk($sformatf("v%0d_reads", idx), 32'(nrd - r0), 32'(v.reads));
      chk($sformatf("v%0d_no_overlap", idx), 32'(overlap_cnt - ov0), 32'd0);
      if (v.writes > 0)
         chk($sformatf("v%0d_write_data", idx), last_wdata, img(v.shape, v.op));
      $display("vec %0d: shape=%0d op=%0d status=%0d ctrl=%h lat=%0d writes=%0d reads=%0d",
               idx, v.shape, v.op, bus.rsp_status, bus.rsp_ctrl, lat, nwr - w0, nrd - r0);
      cfg_err_wr  = 0;
      cfg_err_rd  = 0;
      cfg_corrupt = 0;
   endtask

   vec_t vecs[15];

   initial begin
      bit ok;
      bit quiet;
      int lat;

      // Hand-computed expectations; SFR and shadow start at {CIRCLE, AREA}
      vecs[0]  = mk(3'd1, 3'd1, 0, 0, 0, 0, 2'd0, img(3'd1, 3'd1), 1, 1, 5);  // RECT,PERIM -> OK
      vecs[1]  = mk(3'd7, 3'd2, 0, 0, 0, 0, 2'd0, img(3'd1, 3'd2), 1, 1, 5);  // KEEP,IS_SQUARE on RECT -> OK
      vecs[2]  = mk(3'd0, 3'd7, 0, 0, 0, 0, 2'd1, img(3'd1, 3'd2), 1, 1, 5);  // CIRCLE,KEEP(IS_SQUARE) -> REJECTED
      vecs[3]  = mk(3'd5, 3'd0, 0, 0, 0, 0, 2'd1, img(3'd1, 3'd2), 1, 1, 5);  // reserved shape -> REJECTED
      vecs[4]  = mk(3'd2, 3'd4, 0, 0, 0, 0, 2'd1, img(3'd1, 3'd2), 1, 1, 5);  // reserved op -> REJECTED
      vecs[5]  = mk(3'd3, 3'd0, 0, 0, 0, 0, 2'd0, img(3'd3, 3'd0), 1, 1, 5);  // TRI,AREA -> OK
      vecs[6]  = mk(3'd0, 3'd0, 1, 0, 0, 4, 2'd2, 32'd0,           1, 0, 3);  // write error, 4-cycle stall
      vecs[7]  = mk(3'd7, 3'd1, 0, 0, 0, 0, 2'd0, img(3'd3, 3'd1), 1, 1, 5);  // shadow kept TRI -> OK
      vecs[8]  = mk(3'd0, 3'd1, 0, 1, 0, 0, 2'd2, img(3'd0, 3'd1), 1, 1, 5);  // read error, SFR did change
      vecs[9]  = mk(3'd7, 3'd7, 0, 0, 0, 0, 2'd3, img(3'd0, 3'd1), 3, 3, 13); // stale shadow -> MISMATCH
      vecs[10] = mk(3'd7, 3'd0, 0, 0, 0, 0, 2'd0, img(3'd0, 3'd0), 1, 1, 5);  // resynced CIRCLE -> OK
      vecs[11] = mk(3'd2, 3'd0, 0, 0, 3, 0, 2'd3, img(3'd3, 3'd1), 3, 3, 13); // readback always wrong
      vecs[12] = mk(3'd7, 3'd1, 0, 0, 0, 0, 2'd3, img(3'd2, 3'd1), 3, 3, 13); // KEEP from bogus TRI -> MISMATCH
      vecs[13] = mk(3'd7, 3'd2, 0, 0, 0, 0, 2'd0, img(3'd2, 3'd2), 1, 1, 5);  // KEEP from SQUARE -> OK
      vecs[14] = mk(3'd1, 3'd0, 0, 0, 1, 0, 2'd0, img(3'd1, 3'd0), 2, 2, 9);  // one bad read, retry OK

      rst           = 1'b1;
      bus.req_valid = 1'b0;
      bus.req_shape = CIRCLE;
      bus.req_op    = AREA;
      bus.rsp_ready = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_req_ready", 32'(bus.req_ready), 32'd1);
      chk("rst_write", 32'(bus.write), 32'd0);
      chk("rst_write_data", bus.write_data, 32'd0);
      chk("rst_read", 32'(bus.read), 32'd0);
      chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
      chk("rst_rsp_status", 32'(bus.rsp_status), 32'd0);
      chk("rst_rsp_ctrl", bus.rsp_ctrl, 32'd0);
      rst = 1'b0;
      @(negedge clk);

      for (int i = 0; i < 15; i++) run_req(vecs[i], i);

      // Reset in the middle of a transaction (in RD_RESP, cycle 4 after accept)
      wait_idle(ok);
      chk("abort_idle", 32'(ok), 32'd1);
      bus.req_valid = 1'b1;
      bus.req_shape = SQUARE;
      bus.req_op    = PERIMETER;
      lat = 0;
      do begin
         @(negedge clk);
         bus.req_valid = 1'b0;
         lat++;
      end while (lat < 4);
      chk("abort_pre_req_ready", 32'(bus.req_ready), 32'd0);
      rst = 1'b1;
      #1;
      chk("abort_write", 32'(bus.write), 32'd0);
      chk("abort_read", 32'(bus.read), 32'd0);
      chk("abort_rsp_valid", 32'(bus.rsp_valid), 32'd0);
      chk("abort_req_ready", 32'(bus.req_ready), 32'd1);
      chk("abort_rsp_ctrl", bus.rsp_ctrl, 32'd0);
      @(negedge clk);
      rst = 1'b0;
      quiet = 1;
      repeat (8) begin
         @(negedge clk);
         if (bus.rsp_valid || bus.write || bus.read) quiet = 0;
      end
      chk("abort_no_response", 32'(quiet), 32'd1);
      $display("abort: rst in RD_RESP, outputs quiet=%0d", quiet);

      // KEEP_SHAPE must now resolve to CIRCLE, making IS_SQUARE illegal
      run_req(mk(3'd7, 3'd2, 0, 0, 0, 0, 2'd1, img(3'd0, 3'd0), 1, 1, 5), 15);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
